// File: rtl/dnp3_link_tx.sv
// DNP3 link-layer transmitter for header-only frames (LEN=5, no user data).
// Emits 05 64 05 CTRL DST_lo DST_hi SRC_lo SRC_hi CRC_lo CRC_hi byte-serially over a valid/ready handshake.
module dnp3_link_tx #(
    parameter logic [15:0] MY_ADDRESS = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [7:0]  control,
    input  logic [15:0] dest_addr,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_sent
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  START1   = 8'h05;
    localparam logic [7:0]  START2   = 8'h64;
    localparam logic [7:0]  LEN      = 8'h05;
    localparam logic [15:0] CRC_POLY = 16'hA6BC;
    localparam logic [3:0]  LAST_IDX = 4'd9;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [15:0] dst_q, dst_d;

    logic        hs;
    logic        start;
    logic [7:0]  byte_cur;
    logic [15:0] crc_next;

    // Reflected DNP3 CRC-16: eight LSB-first bit steps for one byte.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ CRC_POLY;
            else      c = c >> 1;
        end
        return c;
    endfunction

    always_comb begin
        byte_cur = 8'h00;
        case (idx_q)
            4'd0:    byte_cur = START1;
            4'd1:    byte_cur = START2;
            4'd2:    byte_cur = LEN;
            4'd3:    byte_cur = ctrl_q;
            4'd4:    byte_cur = dst_q[7:0];
            4'd5:    byte_cur = dst_q[15:8];
            4'd6:    byte_cur = MY_ADDRESS[7:0];
            4'd7:    byte_cur = MY_ADDRESS[15:8];
            4'd8:    byte_cur = ~crc_q[7:0];
            4'd9:    byte_cur = ~crc_q[15:8];
            default: byte_cur = 8'h00;
        endcase
    end

    assign hs       = (state_q == ST_SEND) && tx_ready;
    assign start    = send && (state_q != ST_SEND);
    assign crc_next = crc_byte(crc_q, byte_cur);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            crc_q   <= 16'h0000;
            ctrl_q  <= 8'h00;
            dst_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            crc_q   <= crc_d;
            ctrl_q  <= ctrl_d;
            dst_q   <= dst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (send) state_d = ST_SEND;
            ST_SEND: if (hs && idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = send ? ST_SEND : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame fields are captured once at start so input changes mid-frame are invisible.
    always_comb begin
        idx_d  = idx_q;
        crc_d  = crc_q;
        ctrl_d = ctrl_q;
        dst_d  = dst_q;
        if (start) begin
            idx_d  = 4'd0;
            crc_d  = 16'h0000;
            ctrl_d = control;
            dst_d  = dest_addr;
        end else if (hs) begin
            idx_d = idx_q + 4'd1;
            if (idx_q < 4'd8) crc_d = crc_next;
        end
    end

    always_comb begin
        busy       = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        frame_sent = 1'b0;
        case (state_q)
            ST_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = byte_cur;
            end
            ST_DONE: frame_sent = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dnp3_link_tx.sv
// Scoreboard bench for dnp3_link_tx: expected frame bytes are queued when a send is
// issued and popped as the DUT hands bytes over the tx_valid/tx_ready handshake.
module tb_dnp3_link_tx;

    logic        clk;
    logic        rst;
    logic        send;
    logic [7:0]  control;
    logic [15:0] dest_addr;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        frame_sent;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] exp_q[$];
    int  fs_cnt    = 0;
    int  acc_cnt   = 0;
    int  busy_cyc  = 0;
    bit  bp_mode   = 0;
    bit  stall_prev = 0;
    logic [7:0] stall_data = 8'h00;

    dnp3_link_tx #(.MY_ADDRESS(16'h0001)) dut (
        .clk        (clk),
        .rst        (rst),
        .send       (send),
        .control    (control),
        .dest_addr  (dest_addr),
        .busy       (busy),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_sent (frame_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA6BC) : (r >> 1);
        return r;
    endfunction

    function automatic logic [15:0] crc_final(input logic [7:0] hdr[8]);
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 0; i < 8; i++) c = crc_upd(c, hdr[i]);
        return ~c;
    endfunction

    task automatic push_frame(input logic [7:0] c, input logic [15:0] d);
        logic [7:0]  hdr[8];
        logic [15:0] crc;
        hdr[0] = 8'h05; hdr[1] = 8'h64; hdr[2] = 8'h05; hdr[3] = c;
        hdr[4] = d[7:0]; hdr[5] = d[15:8]; hdr[6] = 8'h01; hdr[7] = 8'h00;
        crc = crc_final(hdr);
        for (int i = 0; i < 8; i++) exp_q.push_back(hdr[i]);
        exp_q.push_back(crc[7:0]);
        exp_q.push_back(crc[15:8]);
    endtask

    // Called at posedge+1 with the DUT idle; leaves inputs scrambled to prove latching.
    task automatic send_frame(input logic [7:0] c, input logic [15:0] d);
        push_frame(c, d);
        send = 1'b1; control = c; dest_addr = d;
        @(posedge clk); #1;
        send = 1'b0; control = 8'($urandom); dest_addr = 16'($urandom);
    endtask

    task automatic wait_fs(input int target, input string tag);
        int n;
        n = 0;
        while (fs_cnt < target && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(fs_cnt >= target), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (busy) busy_cyc++;
            if (frame_sent) fs_cnt++;
            if (stall_prev) chk("stable", {24'h0, tx_data}, {24'h0, stall_data});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("extra_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else                   chk("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                acc_cnt++;
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) tx_ready = ($urandom_range(0, 9) < 3);
    end

    initial begin
        logic [7:0] ascii[9];
        logic [15:0] c;
        int base, n;

        rst = 1'b1; send = 1'b0; control = 8'h00; dest_addr = 16'h0000; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {31'h0, busy}, 32'd0);
        chk("rst_valid", {31'h0, tx_valid}, 32'd0);
        chk("rst_data",  {24'h0, tx_data}, 32'd0);
        chk("rst_fs",    {31'h0, frame_sent}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic frame, ready tied high
        tx_ready = 1'b1; busy_cyc = 0;
        send_frame(8'h00, 16'h0004);
        wait_fs(1, "t1_timeout");
        chk("t1_busy_cycles", busy_cyc, 32'd10);
        chk("t1_fs_count", fs_cnt, 32'd1);
        chk("t1_queue_empty", exp_q.size(), 32'd0);

        // 2: golden model anchor, then random headers
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 16'h0000;
        for (int i = 0; i < 9; i++) c = crc_upd(c, ascii[i]);
        chk("crc_check_value", {16'h0, ~c}, 32'h0000_EA82);
        for (int k = 0; k < 3; k++) begin
            base = fs_cnt;
            send_frame(8'($urandom), 16'($urandom));
            wait_fs(base + 1, "t2_timeout");
        end
        chk("t2_queue_empty", exp_q.size(), 32'd0);

        // 3: random backpressure
        bp_mode = 1; base = fs_cnt;
        send_frame(8'h00, 16'h0004);
        wait_fs(base + 1, "t3_timeout");
        bp_mode = 0; #1 tx_ready = 1'b1;
        chk("t3_queue_empty", exp_q.size(), 32'd0);

        // 4: second send while busy must be ignored
        base = fs_cnt; acc_cnt = 0;
        send_frame(8'h44, 16'h1234);
        n = 0;
        while (acc_cnt < 4 && n < 100) begin @(posedge clk); #1; n++; end
        chk("t4_reach_byte4", 32'(acc_cnt >= 4), 32'd1);
        send = 1'b1; control = 8'h55; dest_addr = 16'hBEEF;
        @(posedge clk); #1;
        send = 1'b0;
        wait_fs(base + 1, "t4_timeout");
        repeat (20) @(posedge clk);
        #1;
        chk("t4_one_frame", fs_cnt - base, 32'd1);
        chk("t4_bytes", acc_cnt, 32'd10);

        // 5: back-to-back via send in the frame_sent cycle
        base = fs_cnt; acc_cnt = 0;
        send_frame(8'hC4, 16'h0A0B);
        push_frame(8'h0B, 16'h7788);
        n = 0;
        while (!frame_sent && n < 100) begin @(posedge clk); #1; n++; end
        chk("t5_first_fs", {31'h0, frame_sent}, 32'd1);
        send = 1'b1; control = 8'h0B; dest_addr = 16'h7788;
        @(posedge clk); #1;
        send = 1'b0;
        chk("t5_next_valid", {31'h0, tx_valid}, 32'd1);
        chk("t5_next_byte", {24'h0, tx_data}, 32'h05);
        wait_fs(base + 2, "t5_timeout");
        chk("t5_two_pulses", fs_cnt - base, 32'd2);
        chk("t5_20_bytes", acc_cnt, 32'd20);

        // 6: asynchronous reset during byte 6
        base = fs_cnt; acc_cnt = 0;
        send_frame(8'h73, 16'h0102);
        n = 0;
        while (acc_cnt < 6 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t6_valid_drop", {31'h0, tx_valid}, 32'd0);
        chk("t6_busy_drop",  {31'h0, busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_fs", fs_cnt - base, 32'd0);
        send_frame(8'h73, 16'h0102);
        wait_fs(base + 1, "t6_timeout");
        chk("t6_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
